// File: rtl/bcd_acc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bcd_acc_pkg
//  Description : Shared types and constants for the BCD digit accumulator.
//                Holds the FSM state encoding and the BCD digit limits.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [4:0] BCD_RADIX = 5'd10;

endpackage : bcd_acc_pkg
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_step
//  Description : Combinational single-digit BCD adder with carry in/out.
//  Ports       : a, b  - BCD digit operands (0-9)
//                cin   - carry in
//                sum   - BCD result digit
//                cout  - decimal carry out (raw sum exceeded 9)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_step
    import bcd_acc_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_raw;
    logic [4:0] w_adj;

    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        w_adj = w_raw - BCD_RADIX;
        if (w_raw > {1'b0, BCD_MAX}) begin
            sum  = w_adj[3:0];
            cout = 1'b1;
        end else begin
            sum  = w_raw[3:0];
            cout = 1'b0;
        end
    end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_digit_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_accumulator
//  Description : Adds one BCD digit to a two-digit BCD running total (00-99)
//                on each press of Enter. Enter and Clear are synchronised;
//                Enter is rising-edge detected so a held press adds once.
//  Ports       : Clock  - system clock, rising edge
//                Resetn - asynchronous active-low reset
//                D      - operand digit, legal 0-9
//                Enter  - raw add request (level)
//                Clear  - raw synchronous clear of total and flags
//                Ones   - BCD ones digit of total
//                Tens   - BCD tens digit of total
//                Ovf    - sticky tens-digit carry out
//                Err    - last request carried a non-BCD operand
//                Busy   - FSM in ADD or HOLD
//  Options     : BCD_ACC_SATURATE_EN - saturate at 99 on overflow instead of
//                wrapping modulo 100
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_accumulator
    import bcd_acc_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal 2-3
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [3:0] D,
    input  logic       Enter,
    input  logic       Clear,
    output logic [3:0] Ones,
    output logic [3:0] Tens,
    output logic       Ovf,
    output logic       Err,
    output logic       Busy
);

    logic [SYNC_STAGES-1:0] r_enter_sync;
    logic [SYNC_STAGES-1:0] r_clear_sync;
    logic                   r_enter_dly;
    logic [3:0]             r_operand;
    acc_state_t             r_state;
    acc_state_t             w_state_nxt;

    logic       w_enter_s;
    logic       w_clear_s;
    logic       w_rise;
    logic       w_load;
    logic       w_add;
    logic       w_err_set;
    logic       w_err_clr;
    logic [3:0] w_ones_sum;
    logic [3:0] w_tens_sum;
    logic       w_ones_cout;
    logic       w_tens_cout;
    logic [3:0] w_ones_nxt;
    logic [3:0] w_tens_nxt;

    assign w_enter_s = r_enter_sync[SYNC_STAGES-1];
    assign w_clear_s = r_clear_sync[SYNC_STAGES-1];
    assign w_rise    = w_enter_s & ~r_enter_dly;
    assign Busy      = (r_state == ADD) || (r_state == HOLD);

    // Synchronisers plus the Enter edge-detect delay flop. The delay flop
    // keeps tracking Enter through Clear so a press held across Clear never
    // produces a late rise.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_enter_sync <= '0;
            r_clear_sync <= '0;
            r_enter_dly  <= 1'b0;
        end else begin
            r_enter_sync <= {r_enter_sync[SYNC_STAGES-2:0], Enter};
            r_clear_sync <= {r_clear_sync[SYNC_STAGES-2:0], Clear};
            r_enter_dly  <= w_enter_s;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_add       = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    if (D <= BCD_MAX) begin
                        w_load      = 1'b1;
                        w_err_clr   = 1'b1;
                        w_state_nxt = ADD;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            ADD: begin
                w_add       = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!w_enter_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Clear overrides everything; parking in HOLD swallows a held Enter
        // and drops any add that was about to be applied.
        if (w_clear_s) begin
            w_state_nxt = HOLD;
            w_load      = 1'b0;
            w_add       = 1'b0;
            w_err_set   = 1'b0;
            w_err_clr   = 1'b0;
        end
    end

    bcd_digit_step u_ones_step (
        .a    (Ones),
        .b    (r_operand),
        .cin  (1'b0),
        .sum  (w_ones_sum),
        .cout (w_ones_cout)
    );

    bcd_digit_step u_tens_step (
        .a    (Tens),
        .b    (4'd0),
        .cin  (w_ones_cout),
        .sum  (w_tens_sum),
        .cout (w_tens_cout)
    );

    // On a tens carry the step result is already 0 (10 - 10), which gives
    // modulo-100 wrap for free; the saturating build overrides it with 99.
    always_comb begin
        w_ones_nxt = w_ones_sum;
        w_tens_nxt = w_tens_sum;
`ifdef BCD_ACC_SATURATE_EN
        if (w_tens_cout) begin
            w_ones_nxt = BCD_MAX;
            w_tens_nxt = BCD_MAX;
        end
`else
        if (w_tens_cout) begin
            w_tens_nxt = 4'd0;
        end
`endif
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_operand <= 4'd0;
            Ones      <= 4'd0;
            Tens      <= 4'd0;
            Ovf       <= 1'b0;
            Err       <= 1'b0;
        end else if (w_clear_s) begin
            Ones      <= 4'd0;
            Tens      <= 4'd0;
            Ovf       <= 1'b0;
            Err       <= 1'b0;
        end else begin
            if (w_load) begin
                r_operand <= D;
            end
            if (w_err_set) begin
                Err <= 1'b1;
            end else if (w_err_clr) begin
                Err <= 1'b0;
            end
            if (w_add) begin
                Ones <= w_ones_nxt;
                Tens <= w_tens_nxt;
                if (w_tens_cout) begin
                    Ovf <= 1'b1;
                end
            end
        end
    end

endmodule : bcd_digit_accumulator
`default_nettype wire

// File: tb/tb_bcd_digit_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_digit_accumulator
//  Description : Directed self-checking bench for bcd_digit_accumulator.
//                Expected totals are written as BCD hex ({Tens,Ones}).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_digit_accumulator;

    logic       Clock;
    logic       Resetn;
    logic [3:0] D;
    logic       Enter;
    logic       Clear;
    logic [3:0] Ones;
    logic [3:0] Tens;
    logic       Ovf;
    logic       Err;
    logic       Busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    bcd_digit_accumulator #(.SYNC_STAGES(2)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .D      (D),
        .Enter  (Enter),
        .Clear  (Clear),
        .Ones   (Ones),
        .Tens   (Tens),
        .Ovf    (Ovf),
        .Err    (Err),
        .Busy   (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] total,
                               input logic ovf, input logic err, input logic busy);
        check_eq($sformatf("%s.total", tag), {Tens, Ones}, total);
        check_eq($sformatf("%s.ovf", tag),  {7'd0, Ovf},  {7'd0, ovf});
        check_eq($sformatf("%s.err", tag),  {7'd0, Err},  {7'd0, err});
        check_eq($sformatf("%s.busy", tag), {7'd0, Busy}, {7'd0, busy});
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge Clock);
        D     = d;
        Enter = 1'b1;
        repeat (4) @(negedge Clock);
        Enter = 1'b0;
        repeat (6) @(negedge Clock);
    endtask

    task automatic do_clear();
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        repeat (5) @(negedge Clock);
    endtask

    initial begin
        Resetn = 1'b0;
        D      = 4'd0;
        Enter  = 1'b0;
        Clear  = 1'b0;
        repeat (3) @(negedge Clock);
        check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        // Basic adds, second one with per-edge latency checks.
        press(4'd7);
        check_state("add7", 8'h07, 1'b0, 1'b0, 1'b0);

        @(negedge Clock);
        D     = 4'd5;
        Enter = 1'b1;
        @(posedge Clock); #1;
        check_eq("e1.busy", {7'd0, Busy}, 8'd0);
        @(posedge Clock); #1;
        check_eq("e2.busy", {7'd0, Busy}, 8'd0);
        @(posedge Clock); #1;
        check_eq("e3.busy", {7'd0, Busy}, 8'd1);
        check_eq("e3.total", {Tens, Ones}, 8'h07);
        @(posedge Clock); #1;
        check_eq("e4.total", {Tens, Ones}, 8'h12);
        @(negedge Clock);
        Enter = 1'b0;
        repeat (6) @(negedge Clock);
        check_state("add5", 8'h12, 1'b0, 1'b0, 1'b0);

        // Non-BCD operand rejected, Err timing at edge 3.
        @(negedge Clock);
        D     = 4'd12;
        Enter = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        check_eq("bad.e2.err", {7'd0, Err}, 8'd0);
        @(posedge Clock); #1;
        check_eq("bad.e3.err", {7'd0, Err}, 8'd1);
        @(negedge Clock);
        Enter = 1'b0;
        repeat (8) @(negedge Clock);
        check_state("bad12", 8'h12, 1'b0, 1'b1, 1'b0);
        press(4'd3);
        check_state("add3", 8'h15, 1'b0, 1'b0, 1'b0);

        // Long hold adds exactly once; D changes mid-hold are ignored.
        do_clear();
        check_state("clr1", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        D     = 4'd1;
        Enter = 1'b1;
        repeat (25) @(negedge Clock);
        check_state("hold.mid", 8'h01, 1'b0, 1'b0, 1'b1);
        D = 4'd9;
        repeat (25) @(negedge Clock);
        Enter = 1'b0;
        @(posedge Clock); #1;
        check_eq("rel.a.busy", {7'd0, Busy}, 8'd1);
        @(posedge Clock); #1;
        check_eq("rel.b.busy", {7'd0, Busy}, 8'd1);
        @(posedge Clock); #1;
        check_eq("rel.c.busy", {7'd0, Busy}, 8'd0);
        repeat (3) @(negedge Clock);
        check_state("hold.end", 8'h01, 1'b0, 1'b0, 1'b0);

        // Build 95, then overflow.
        do_clear();
        for (int i = 0; i < 10; i++) press(4'd9);
        check_state("to90", 8'h90, 1'b0, 1'b0, 1'b0);
        press(4'd5);
        check_state("to95", 8'h95, 1'b0, 1'b0, 1'b0);
        press(4'd7);
`ifdef BCD_ACC_SATURATE_EN
        check_state("ovf1", 8'h99, 1'b1, 1'b0, 1'b0);
`else
        check_state("ovf1", 8'h02, 1'b1, 1'b0, 1'b0);
`endif
        press(4'd1);
`ifdef BCD_ACC_SATURATE_EN
        check_state("ovf2", 8'h99, 1'b1, 1'b0, 1'b0);
`else
        check_state("ovf2", 8'h03, 1'b1, 1'b0, 1'b0);
`endif

        // Clear and Enter together from 40.
        do_clear();
        check_state("clr2", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) press(4'd9);
        press(4'd4);
        check_state("to40", 8'h40, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        D     = 4'd3;
        Clear = 1'b1;
        Enter = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        repeat (8) @(negedge Clock);
        check_state("clr.enter", 8'h00, 1'b0, 1'b0, 1'b1);
        Enter = 1'b0;
        repeat (6) @(negedge Clock);
        check_state("clr.rel", 8'h00, 1'b0, 1'b0, 1'b0);
        press(4'd2);
        check_state("after.clr", 8'h02, 1'b0, 1'b0, 1'b0);

        // Reset asserted while in ADD, Enter held throughout.
        @(negedge Clock);
        D     = 4'd1;
        Enter = 1'b1;
        repeat (3) @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check_state("rst.mid", 8'h00, 1'b0, 1'b0, 1'b0);
        #4;
        Resetn = 1'b1;
        repeat (10) @(negedge Clock);
        check_state("rst.held", 8'h01, 1'b0, 1'b0, 1'b1);
        Enter = 1'b0;
        repeat (6) @(negedge Clock);
        check_state("rst.end", 8'h01, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_bcd_digit_accumulator
`default_nettype wire
